mem_stage: RTL and testbench

- EX/MEM pipeline register plus data-memory access controller for the 5-stage RISC-V core.
- Captures ALU result, store data and control from EX, drives a req/ack data-memory bus with byte enables, and formats load data for WB.
- Supplies ALUResult_mem, rdAddr_mem and RegWrite_mem back to the EX forwarding logic.
- Asserts stall_mem to freeze IF/ID/EX while a memory access is outstanding.

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// EX/MEM pipeline register and data-memory access controller: captures EX results,
// runs a req/ack bus transaction with byte enables, and formats load data for WB.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        MemtoReg_mem,
  output logic [31:0] MemDout_mem,
  output logic        stall_mem,
  output logic        BusErr_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0]   alu_q, wdata_q;
  logic [4:0]    rd_q;
  logic [2:0]    f3_q;
  logic          rw_q, mr_q, mw_q, mtr_q, done_q;

  logic [1:0]    off;
  logic          mem_op, legal, pending, timeout;
  logic [31:0]   rshift, load_fmt;
  logic [15:0]   half;

  assign off     = alu_q[1:0];
  assign mem_op  = mr_q | mw_q;
  assign pending = mem_op & legal & ~done_q;
  assign timeout = (state == ST_WAIT) && (cnt == CW'(TIMEOUT - 1)) && !dmem_ack;

  // NOTE: every pipeline register is reset to a bubble so that a reset mid-access
  // drops the request immediately through the combinational outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (!stall_mem) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      alu_q   <= ALUResult_ex;
      wdata_q <= MemWriteData_ex;
      rd_q    <= rdAddr_ex;
      f3_q    <= funct3_ex;
      rw_q    <= RegWrite_ex;
      mr_q    <= MemRead_ex;
      mw_q    <= MemWrite_ex;
      mtr_q   <= MemtoReg_ex;
      done_q  <= 1'b0;
    end else begin
      done_q  <= done_q | (pending & (dmem_ack | timeout));
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned
    // (which would infer a latch).
    legal = 1'b0;
    if (mr_q) begin
      case (f3_q)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~off[0];
        3'b010:         legal = (off == 2'b00);
        default:        legal = 1'b0;
      endcase
    end else if (mw_q) begin
      case (f3_q)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~off[0];
        3'b010:  legal = (off == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pending && !dmem_ack) state_next = ST_WAIT;
      ST_WAIT: if (!pending || dmem_ack || timeout) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Counts request cycles already elapsed, so the first WAIT cycle sees 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        cnt <= '0;
    else if (state_next == ST_IDLE)   cnt <= '0;
    else                              cnt <= cnt + CW'(1);
  end

  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = wdata_q;
    if (mw_q) begin
      case (f3_q[1:0])
        2'b00:   dmem_wdata = {4{wdata_q[7:0]}};
        2'b01:   dmem_wdata = {2{wdata_q[15:0]}};
        default: dmem_wdata = wdata_q;
      endcase
    end
    if (pending) begin
      if (mw_q) begin
        case (f3_q[1:0])
          2'b00:   dmem_be = 4'b0001 << off;
          2'b01:   dmem_be = 4'b0011 << off;
          default: dmem_be = 4'b1111;
        endcase
      end else begin
        dmem_be = 4'b1111;
      end
    end
  end

  assign rshift = dmem_rdata >> {off, 3'b000};
  assign half   = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_fmt = dmem_rdata;
    case (f3_q)
      3'b000:  load_fmt = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  load_fmt = {24'b0, rshift[7:0]};
      3'b001:  load_fmt = {{16{half[15]}}, half};
      3'b101:  load_fmt = {16'b0, half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  assign dmem_req      = pending;
  assign dmem_we       = pending & mw_q;
  assign dmem_addr     = {alu_q[31:2], 2'b00};
  assign stall_mem     = pending & ~dmem_ack & ~timeout;
  assign BusErr_mem    = (mem_op & ~legal & ~done_q) | timeout;
  assign MemDout_mem   = (mr_q && pending && dmem_ack) ? load_fmt : 32'h0;
  assign ALUResult_mem = alu_q;
  assign rdAddr_mem    = rd_q;
  assign RegWrite_mem  = rw_q & ~BusErr_mem;
  assign MemtoReg_mem  = mtr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected retire records,
// a negedge monitor pops and compares whenever an instruction leaves MEM.
module tb_mem_stage;

  localparam int TO     = 16;
  localparam int TMO    = -1;
  localparam int NO_ACK = -2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] ALUResult_mem, MemDout_mem, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem, MemtoReg_mem, stall_mem, BusErr_mem;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_be;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex),
    .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .funct3_ex(funct3_ex),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
    .RegWrite_mem(RegWrite_mem), .MemtoReg_mem(MemtoReg_mem),
    .MemDout_mem(MemDout_mem), .stall_mem(stall_mem), .BusErr_mem(BusErr_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] dout;
    logic        err;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] alu, input logic [4:0] rd,
                              input logic rw, input logic [31:0] dout, input logic err,
                              input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata, input int stalls);
    exp_t e;
    e.name = name; e.alu = alu; e.rd = rd; e.rw = rw; e.dout = dout; e.err = err;
    e.req = req; e.we = we; e.be = be; e.addr = addr; e.wdata = wdata; e.stalls = stalls;
    return e;
  endfunction

  task automatic bubble_ex();
    ALUResult_ex = '0; MemWriteData_ex = '0; rdAddr_ex = '0; RegWrite_ex = 1'b0;
    MemRead_ex = 1'b0; MemWrite_ex = 1'b0; MemtoReg_ex = 1'b0; funct3_ex = '0;
  endtask

  // wait_n >= 0: ack after wait_n stall cycles; TMO: never ack; NO_ACK: single cycle, no ack.
  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] rdata, input int wait_n);
    ALUResult_ex = alu; MemWriteData_ex = wd; rdAddr_ex = rd; RegWrite_ex = rw;
    MemRead_ex = mr; MemWrite_ex = mw; MemtoReg_ex = mr; funct3_ex = f3;
    @(posedge clk); #1;
    bubble_ex();
    dmem_rdata = rdata;
    dmem_ack   = 1'b0;
    if (wait_n == NO_ACK) begin
      @(posedge clk); #1;
    end else if (wait_n == TMO) begin
      repeat (TO) @(posedge clk);
      #1;
    end else begin
      repeat (wait_n) @(posedge clk);
      #1;
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
  endtask

  int          stall_run = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_run = 0;
    end else if (stall_mem) begin
      if (stall_run == 0) begin
        snap_addr = dmem_addr; snap_be = dmem_be; snap_wdata = dmem_wdata;
      end else begin
        check("hold.addr", dmem_addr, snap_addr);
        check("hold.be", {28'b0, dmem_be}, {28'b0, snap_be});
        check("hold.wdata", dmem_wdata, snap_wdata);
      end
      stall_run++;
    end else if (dmem_req || BusErr_mem || RegWrite_mem) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: unexpected retire alu=0x%08h want no output", ALUResult_mem);
      end else begin
        e = sb.pop_front();
        check({e.name, ".alu"},    ALUResult_mem, e.alu);
        check({e.name, ".rd"},     {27'b0, rdAddr_mem}, {27'b0, e.rd});
        check({e.name, ".rw"},     {31'b0, RegWrite_mem}, {31'b0, e.rw});
        check({e.name, ".dout"},   MemDout_mem, e.dout);
        check({e.name, ".err"},    {31'b0, BusErr_mem}, {31'b0, e.err});
        check({e.name, ".req"},    {31'b0, dmem_req}, {31'b0, e.req});
        check({e.name, ".stalls"}, stall_run, e.stalls);
        if (e.req) begin
          check({e.name, ".we"},    {31'b0, dmem_we}, {31'b0, e.we});
          check({e.name, ".be"},    {28'b0, dmem_be}, {28'b0, e.be});
          check({e.name, ".addr"},  dmem_addr, e.addr);
          check({e.name, ".wdata"}, dmem_wdata, e.wdata);
        end
      end
      stall_run = 0;
    end
  end

  initial begin
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    bubble_ex();
    repeat (2) @(posedge clk);
    #1;
    check("rst.req",   {31'b0, dmem_req}, 32'h0);
    check("rst.stall", {31'b0, stall_mem}, 32'h0);
    check("rst.alu",   ALUResult_mem, 32'h0);
    check("rst.rw",    {31'b0, RegWrite_mem}, 32'h0);
    check("rst.err",   {31'b0, BusErr_mem}, 32'h0);
    check("rst.dout",  MemDout_mem, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    sb.push_back(mk("lw0", 32'h100, 5'd1, 1, 32'hDEADBEEF, 0, 1, 0, 4'hF, 32'h100, 32'h0, 0));
    issue(32'h100, 32'h0, 5'd1, 1, 1, 0, 3'b010, 32'hDEADBEEF, 0);

    sb.push_back(mk("lb", 32'h103, 5'd2, 1, 32'hFFFFFF80, 0, 1, 0, 4'hF, 32'h100, 32'h0, 3));
    issue(32'h103, 32'h0, 5'd2, 1, 1, 0, 3'b000, 32'h80FF1234, 3);

    sb.push_back(mk("lbu", 32'h103, 5'd2, 1, 32'h00000080, 0, 1, 0, 4'hF, 32'h100, 32'h0, 3));
    issue(32'h103, 32'h0, 5'd2, 1, 1, 0, 3'b100, 32'h80FF1234, 3);

    sb.push_back(mk("lh", 32'h102, 5'd8, 1, 32'hFFFF80FF, 0, 1, 0, 4'hF, 32'h100, 32'h0, 0));
    issue(32'h102, 32'h0, 5'd8, 1, 1, 0, 3'b001, 32'h80FF1234, 0);

    sb.push_back(mk("lhu", 32'h102, 5'd9, 1, 32'h000080FF, 0, 1, 0, 4'hF, 32'h100, 32'h0, 2));
    issue(32'h102, 32'h0, 5'd9, 1, 1, 0, 3'b101, 32'h80FF1234, 2);

    sb.push_back(mk("sh", 32'h202, 5'd0, 0, 32'h0, 0, 1, 1, 4'b1100, 32'h200, 32'hABCDABCD, 1));
    issue(32'h202, 32'h0000ABCD, 5'd0, 0, 0, 1, 3'b001, 32'h0, 1);

    sb.push_back(mk("sb", 32'h101, 5'd0, 0, 32'h0, 0, 1, 1, 4'b0010, 32'h100, 32'h55555555, 0));
    issue(32'h101, 32'h12345655, 5'd0, 0, 0, 1, 3'b000, 32'h0, 0);

    sb.push_back(mk("sw", 32'h300, 5'd0, 0, 32'h0, 0, 1, 1, 4'b1111, 32'h300, 32'hCAFEF00D, 0));
    issue(32'h300, 32'hCAFEF00D, 5'd0, 0, 0, 1, 3'b010, 32'h0, 0);

    sb.push_back(mk("lw_mis", 32'h101, 5'd3, 0, 32'h0, 1, 0, 0, 4'h0, 32'h100, 32'h0, 0));
    issue(32'h101, 32'h0, 5'd3, 1, 1, 0, 3'b010, 32'h11111111, 0);

    sb.push_back(mk("ld_f3", 32'h100, 5'd6, 0, 32'h0, 1, 0, 0, 4'h0, 32'h100, 32'h0, 0));
    issue(32'h100, 32'h0, 5'd6, 1, 1, 0, 3'b011, 32'h0, NO_ACK);

    sb.push_back(mk("st_f3", 32'h200, 5'd0, 0, 32'h0, 1, 0, 0, 4'h0, 32'h200, 32'h0, 0));
    issue(32'h200, 32'h1, 5'd0, 0, 0, 1, 3'b100, 32'h0, NO_ACK);

    sb.push_back(mk("sh_mis", 32'h203, 5'd0, 0, 32'h0, 1, 0, 0, 4'h0, 32'h200, 32'h0, 0));
    issue(32'h203, 32'h1234, 5'd0, 0, 0, 1, 3'b001, 32'h0, NO_ACK);

    sb.push_back(mk("lw_tmo", 32'h104, 5'd4, 0, 32'h0, 1, 1, 0, 4'hF, 32'h104, 32'h0, 15));
    issue(32'h104, 32'h0, 5'd4, 1, 1, 0, 3'b010, 32'h0, TMO);

    sb.push_back(mk("lw_ack16", 32'h108, 5'd4, 1, 32'h12345678, 0, 1, 0, 4'hF, 32'h108, 32'h0, 15));
    issue(32'h108, 32'h0, 5'd4, 1, 1, 0, 3'b010, 32'h12345678, 15);

    // Reset while the load sits in WAIT; nothing of it may retire.
    ALUResult_ex = 32'h10C; rdAddr_ex = 5'd7; RegWrite_ex = 1'b1; MemRead_ex = 1'b1;
    MemtoReg_ex = 1'b1; funct3_ex = 3'b010;
    @(posedge clk); #1;
    bubble_ex();
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst.req", {31'b0, dmem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst.req",   {31'b0, dmem_req}, 32'h0);
    check("mid_rst.stall", {31'b0, stall_mem}, 32'h0);
    check("mid_rst.rw",    {31'b0, RegWrite_mem}, 32'h0);
    check("mid_rst.alu",   ALUResult_mem, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_rdata = 32'hFFFFFFFF;
    dmem_ack = 1'b1;
    #1;
    check("late_ack.dout", MemDout_mem, 32'h0);
    check("late_ack.req",  {31'b0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    sb.push_back(mk("add", 32'h7, 5'd5, 1, 32'h0, 0, 0, 0, 4'h0, 32'h4, 32'h0, 0));
    issue(32'h7, 32'h0, 5'd5, 1, 0, 0, 3'b000, 32'h0, NO_ACK);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
